// File: rtl/wbi_pkg.sv
// Shared types for the wishbone interconnect master port.
package wbi_pkg;

  localparam int TID_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD,
    WRSP
  } wbi_mst_st_e;

endpackage

// File: rtl/wbi_mst_tmo.sv
// Response timeout counter for the wishbone master port.
// Only built when WBI_MST_TIMEOUT_EN is defined.
`ifdef WBI_MST_TIMEOUT_EN
module wbi_mst_tmo #(
  parameter int TMO_CYC = 1024
) (
  input  logic mclk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TMO_CYC);

  logic [CW-1:0] r_cnt;

  // Reload on every response activity, count down while waiting for the chain
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule
`endif

// File: rtl/wbi_master_port.sv
// Head of the wishbone interconnect daisy chain: turns one classic/burst
// wishbone master into split cmd/res valid-ready channels, tags commands
// with MST_TID and sequences read/write bursts.
// Optional response timeout: define WBI_MST_TIMEOUT_EN.
module wbi_master_port
  import wbi_pkg::*;
#(
  parameter int               AW      = 32,
  parameter int               DW      = 32,
  parameter int               BW      = 4,
  parameter int               BL      = 10,
  parameter logic [TID_W-1:0] MST_TID = 4'h0,
  parameter int               TMO_CYC = 1024
) (
  input  logic             mclk,
  input  logic             reset,
  // wishbone master side
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic             wbm_we_i,
  input  logic [BW-1:0]    wbm_sel_i,
  input  logic [DW-1:0]    wbm_dat_i,
  input  logic [BL-1:0]    wbm_bl_i,
  input  logic             wbm_bry_i,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_lack_o,
  output logic             wbm_err_o,
  // command channel to the chain
  input  logic             wbd_cmd_wrdy_i,
  output logic             wbd_cmd_wval_o,
  output logic [AW-1:0]    wbd_cmd_adr_o,
  output logic             wbd_cmd_we_o,
  output logic [DW-1:0]    wbd_cmd_dat_o,
  output logic [BW-1:0]    wbd_cmd_sel_o,
  output logic [TID_W-1:0] wbd_cmd_tid_o,
  output logic [BL-1:0]    wbd_cmd_bl_o,
  // response channel from the chain
  output logic             wbd_res_rrdy_o,
  input  logic             wbd_res_rval_i,
  input  logic [DW-1:0]    wbd_res_dat_i,
  input  logic             wbd_res_ack_i,
  input  logic             wbd_res_lack_i,
  input  logic             wbd_res_err_i,
  input  logic [TID_W-1:0] wbd_res_tid_i
);

  localparam logic [BL-1:0] ONE = BL'(1);

  wbi_mst_st_e   r_st;
  logic [AW-1:0] r_adr;
  logic          r_we;
  logic [BW-1:0] r_sel;
  logic [DW-1:0] r_dat;
  logic [BL-1:0] r_bl;
  logic [BL-1:0] r_cnt;
  logic          r_abort;
  logic          r_tid_mis;
  logic          r_drain;

  logic          w_abort;
  logic          w_tid_ok;
  logic          w_wval;
  logic          w_rrdy;
  logic [DW-1:0] w_cmd_dat;
  logic [BW-1:0] w_cmd_sel;
  logic          w_cmd_acc;
  logic          w_res_acc;
  logic          w_res_fwd;
  logic          w_res_mis;
  logic          w_beat_err;
  logic          w_beat_vld;
  logic [BL-1:0] w_cnt_nx;
  logic          w_rd_last;
  logic [BL-1:0] w_bl_in;
  logic          w_tmo_hit;
  logic          w_ack;
  logic          w_lack;
  logic          w_err;
  logic [DW-1:0] w_dat;

  // Master abandoned the cycle (now or earlier in this burst): drain silently
  assign w_abort    = r_abort | ~wbm_cyc_i;
  assign w_tid_ok   = (wbd_res_tid_i == MST_TID);
  assign w_bl_in    = (wbm_bl_i == '0) ? ONE : wbm_bl_i;
  assign w_cnt_nx   = r_cnt + ONE;
  assign w_rd_last  = wbd_res_lack_i | (w_cnt_nx == r_bl);
  assign w_beat_err = wbd_res_err_i | r_tid_mis;
  assign w_beat_vld = wbd_res_ack_i | wbd_res_lack_i;

  // Channel-side handshake and command payload selection
  always_comb begin
    w_wval    = 1'b0;
    w_rrdy    = 1'b0;
    w_cmd_dat = r_dat;
    w_cmd_sel = r_sel;
    case (r_st)
      CMD: w_wval = 1'b1;
      WR: begin
        w_wval    = w_abort ? 1'b1 : wbm_bry_i;
        w_cmd_dat = wbm_dat_i;
        w_cmd_sel = w_abort ? '0 : wbm_sel_i;
        // only early errors and foreign beats are taken while still writing
        w_rrdy    = wbd_res_rval_i & (wbd_res_err_i | ~w_tid_ok);
      end
      RD:      w_rrdy = w_abort | wbm_bry_i | (wbd_res_rval_i & ~w_tid_ok);
      WRSP:    w_rrdy = 1'b1;
      default: w_rrdy = r_drain;
    endcase
  end

  assign w_cmd_acc = w_wval & wbd_cmd_wrdy_i;
  assign w_res_acc = wbd_res_rval_i & w_rrdy;
  assign w_res_fwd = w_res_acc & w_tid_ok;
  assign w_res_mis = w_res_acc & ~w_tid_ok;

`ifdef WBI_MST_TIMEOUT_EN
  logic w_tmo_run;
  logic w_tmo_load;
  logic w_tmo_exp;

  assign w_tmo_run  = (r_st == RD) || (r_st == WRSP);
  assign w_tmo_load = w_cmd_acc || (w_tmo_run && w_res_acc);

  wbi_mst_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .mclk      (mclk),
    .reset     (reset),
    .i_load    (w_tmo_load),
    .i_run     (w_tmo_run),
    .o_expired (w_tmo_exp)
  );

  assign w_tmo_hit = w_tmo_exp & ~w_res_acc;
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Master-side ack/lack/err and read data, forwarded in the same cycle
  always_comb begin
    w_ack  = 1'b0;
    w_lack = 1'b0;
    w_err  = 1'b0;
    w_dat  = '0;
    case (r_st)
      CMD: w_ack = w_cmd_acc & r_we & ~w_abort;
      WR: begin
        w_ack = w_cmd_acc & ~w_abort & ~w_res_fwd;
        w_err = w_res_fwd & ~w_abort;
      end
      RD: begin
        if (!w_abort) begin
          if (w_res_fwd) begin
            if (w_beat_err) begin
              w_err = 1'b1;
            end else if (w_beat_vld) begin
              w_ack  = 1'b1;
              w_lack = w_rd_last;
              w_dat  = wbd_res_dat_i;
            end
          end else if (w_tmo_hit) begin
            w_err  = 1'b1;
            w_lack = 1'b1;
          end
        end
      end
      WRSP: begin
        if (!w_abort) begin
          if (w_res_fwd) begin
            if (w_beat_err) begin
              w_err = 1'b1;
            end else if (wbd_res_lack_i) begin
              w_ack  = 1'b1;
              w_lack = 1'b1;
            end
          end else if (w_tmo_hit) begin
            w_err  = 1'b1;
            w_lack = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Burst sequencer: capture request, count beats, close on lack/err/timeout
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_st      <= IDLE;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
      r_bl      <= '0;
      r_cnt     <= '0;
      r_abort   <= 1'b0;
      r_tid_mis <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      if (w_res_mis) begin
        r_tid_mis <= 1'b1;
      end else if (w_res_fwd) begin
        r_tid_mis <= 1'b0;
      end
      case (r_st)
        IDLE: begin
          r_abort <= 1'b0;
          if (r_drain) begin
            if (w_res_fwd && wbd_res_lack_i) r_drain <= 1'b0;
          end else if (wbm_cyc_i && wbm_stb_i) begin
            r_adr <= wbm_adr_i;
            r_we  <= wbm_we_i;
            r_sel <= wbm_sel_i;
            r_dat <= wbm_dat_i;
            r_bl  <= w_bl_in;
            r_cnt <= '0;
            r_st  <= CMD;
          end
        end
        CMD: begin
          if (!wbm_cyc_i) r_abort <= 1'b1;
          if (w_cmd_acc) begin
            if (!r_we) begin
              r_st <= RD;
            end else if (r_bl == ONE) begin
              r_st <= WRSP;
            end else begin
              r_st  <= WR;
              r_cnt <= ONE;
            end
          end
        end
        WR: begin
          if (!wbm_cyc_i) r_abort <= 1'b1;
          if (w_res_fwd) begin
            r_st <= IDLE;
          end else if (w_cmd_acc) begin
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == r_bl) r_st <= WRSP;
          end
        end
        RD: begin
          if (!wbm_cyc_i) r_abort <= 1'b1;
          if (w_res_fwd) begin
            if (w_beat_err) begin
              r_st <= IDLE;
            end else if (w_beat_vld) begin
              r_cnt <= w_cnt_nx;
              if (w_rd_last) r_st <= IDLE;
            end
          end else if (w_tmo_hit) begin
            r_st    <= IDLE;
            r_drain <= 1'b1;
          end
        end
        WRSP: begin
          if (!wbm_cyc_i) r_abort <= 1'b1;
          if (w_res_fwd && (w_beat_err || wbd_res_lack_i)) begin
            r_st <= IDLE;
          end else if (w_tmo_hit) begin
            r_st    <= IDLE;
            r_drain <= 1'b1;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign wbd_cmd_wval_o = w_wval;
  assign wbd_cmd_adr_o  = r_adr;
  assign wbd_cmd_we_o   = r_we;
  assign wbd_cmd_dat_o  = w_cmd_dat;
  assign wbd_cmd_sel_o  = w_cmd_sel;
  assign wbd_cmd_tid_o  = MST_TID;
  assign wbd_cmd_bl_o   = r_bl;
  assign wbd_res_rrdy_o = w_rrdy;
  assign wbm_ack_o      = w_ack;
  assign wbm_lack_o     = w_lack;
  assign wbm_err_o      = w_err;
  assign wbm_dat_o      = w_dat;

endmodule

// File: tb/tb_wbi_master_port.sv
// Directed bench for wbi_master_port. Inputs change just after the falling
// edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_wbi_master_port;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BL = 10;

  logic          mclk = 1'b0;
  logic          reset;
  logic          cyc, stb, we, bry;
  logic [AW-1:0] adr;
  logic [BW-1:0] sel;
  logic [DW-1:0] dat;
  logic [BL-1:0] bl;
  logic [DW-1:0] dato;
  logic          ack, lack, err;
  logic          wrdy, wval;
  logic [AW-1:0] cadr;
  logic          cwe;
  logic [DW-1:0] cdat;
  logic [BW-1:0] csel;
  logic [3:0]    ctid;
  logic [BL-1:0] cbl;
  logic          rrdy, rval, rack, rlack, rerr;
  logic [DW-1:0] rdat;
  logic [3:0]    rtid;

  int n_cmp = 0;
  int n_mis = 0;
  int n_acc = 0;
  int early = 0;

  always #5 mclk = ~mclk;

  wbi_master_port #(
    .AW(AW), .DW(DW), .BW(BW), .BL(BL), .MST_TID(4'h0), .TMO_CYC(16)
  ) dut (
    .mclk(mclk), .reset(reset),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_adr_i(adr), .wbm_we_i(we),
    .wbm_sel_i(sel), .wbm_dat_i(dat), .wbm_bl_i(bl), .wbm_bry_i(bry),
    .wbm_dat_o(dato), .wbm_ack_o(ack), .wbm_lack_o(lack), .wbm_err_o(err),
    .wbd_cmd_wrdy_i(wrdy), .wbd_cmd_wval_o(wval), .wbd_cmd_adr_o(cadr),
    .wbd_cmd_we_o(cwe), .wbd_cmd_dat_o(cdat), .wbd_cmd_sel_o(csel),
    .wbd_cmd_tid_o(ctid), .wbd_cmd_bl_o(cbl),
    .wbd_res_rrdy_o(rrdy), .wbd_res_rval_i(rval), .wbd_res_dat_i(rdat),
    .wbd_res_ack_i(rack), .wbd_res_lack_i(rlack), .wbd_res_err_i(rerr),
    .wbd_res_tid_i(rtid)
  );

  // count accepted command beats on the chain side
  always @(posedge mclk) if (wval && wrdy) n_acc++;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge mclk);
  endtask

  task automatic quiet();
    cyc = 1'b0; stb = 1'b0; bry = 1'b0; wrdy = 1'b0;
    rval = 1'b0; rack = 1'b0; rlack = 1'b0; rerr = 1'b0; rtid = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    adr = '0; we = 1'b0; sel = '0; dat = '0; bl = '0; rdat = '0;
    repeat (2) nx();
    #1;
    chk("rst_wval", wval, 0);
    chk("rst_rrdy", rrdy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_lack", lack, 0);
    chk("rst_err", err, 0);
    chk("rst_adr", cadr, 0);
    nx(); reset = 1'b0;

    // single write
    nx(); cyc = 1; stb = 1; we = 1; adr = 32'h1000_0004; dat = 32'hA5A5_0001; sel = 4'hF; bl = 1; bry = 1;
    #1; chk("A_latency", wval, 0);
    nx(); #1;
    chk("A_wval", wval, 1);
    chk("A_adr", cadr, 32'h1000_0004);
    chk("A_dat", cdat, 32'hA5A5_0001);
    chk("A_tid", ctid, 0);
    chk("A_bl", cbl, 1);
    chk("A_we", cwe, 1);
    chk("A_ack_stall", ack, 0);
    wrdy = 1; #1; chk("A_ack", ack, 1);
    nx(); wrdy = 0; #1;
    chk("A_wval_off", wval, 0);
    chk("A_rrdy", rrdy, 1);
    chk("A_nolack", lack, 0);
    rval = 1; rack = 1; rlack = 1; rtid = 0; #1;
    chk("A_lack", lack, 1);
    chk("A_lack_ack", ack, 1);
    chk("A_err", err, 0);
    nx(); quiet(); #1; chk("A_idle", rrdy, 0);

    // read burst of 4 with a 2-cycle master stall
    nx(); cyc = 1; stb = 1; we = 0; adr = 32'h2000_0000; bl = 4; bry = 1;
    nx(); wrdy = 1; #1;
    chk("B_wval", wval, 1);
    chk("B_we", cwe, 0);
    chk("B_bl", cbl, 4);
    chk("B_noack", ack, 0);
    nx(); wrdy = 0; rval = 1; rack = 1; rdat = 32'hD000_0000; #1;
    chk("B_rrdy1", rrdy, 1); chk("B_ack1", ack, 1); chk("B_dat1", dato, 32'hD000_0000); chk("B_lack1", lack, 0);
    nx(); rdat = 32'hD000_0001; #1;
    chk("B_ack2", ack, 1); chk("B_dat2", dato, 32'hD000_0001);
    nx(); bry = 0; rdat = 32'hD000_0002; #1;
    chk("B_stall1_rrdy", rrdy, 0); chk("B_stall1_ack", ack, 0);
    nx(); #1; chk("B_stall2_rrdy", rrdy, 0);
    nx(); bry = 1; #1;
    chk("B_ack3", ack, 1); chk("B_dat3", dato, 32'hD000_0002); chk("B_lack3", lack, 0);
    nx(); rdat = 32'hD000_0003; #1;
    chk("B_ack4", ack, 1); chk("B_lack4", lack, 1); chk("B_dat4", dato, 32'hD000_0003);
    nx(); quiet(); #1; chk("B_idle", rrdy, 0);

    // write burst of 3 with wrdy toggling
    n_acc = 0;
    nx(); cyc = 1; stb = 1; we = 1; adr = 32'h3000_0000; bl = 3; dat = 32'hC0DE_0000; sel = 4'h3; bry = 1; wrdy = 0;
    nx(); #1; chk("C_wval", wval, 1); chk("C_dat0", cdat, 32'hC0DE_0000); chk("C_ack0", ack, 0);
    nx(); #1; chk("C_hold_dat0", cdat, 32'hC0DE_0000); chk("C_hold_adr0", cadr, 32'h3000_0000);
    wrdy = 1; #1; chk("C_ack1", ack, 1);
    nx(); dat = 32'hC0DE_0001; sel = 4'hC; wrdy = 0; #1;
    chk("C_dat1", cdat, 32'hC0DE_0001); chk("C_sel1", csel, 4'hC); chk("C_adr1", cadr, 32'h3000_0000); chk("C_stall_ack", ack, 0);
    nx(); #1; chk("C_hold_dat1", cdat, 32'hC0DE_0001); chk("C_hold_wval", wval, 1);
    wrdy = 1; #1; chk("C_ack2", ack, 1);
    nx(); dat = 32'hC0DE_0002; wrdy = 0; #1; chk("C_dat2", cdat, 32'hC0DE_0002);
    wrdy = 1; #1; chk("C_ack3", ack, 1);
    nx(); wrdy = 0; #1; chk("C_wval_off", wval, 0); chk("C_rrdy", rrdy, 1); chk("C_beats", n_acc, 3);
    rval = 1; rack = 1; rlack = 1; #1; chk("C_lack", lack, 1);
    nx(); quiet(); #1; chk("C_idle", wval, 0);

    // foreign tid response dropped, err on next forwarded beat
    nx(); cyc = 1; stb = 1; we = 0; adr = 32'h5000_0000; bl = 1; bry = 1;
    nx(); wrdy = 1;
    nx(); wrdy = 0; bry = 0; rval = 1; rack = 1; rlack = 1; rtid = 4'h5; rdat = 32'hBAD0_BAD0; #1;
    chk("E_rrdy", rrdy, 1); chk("E_noack", ack, 0); chk("E_noerr", err, 0); chk("E_dat", dato, 0);
    nx(); rtid = 4'h0; rdat = 32'h600D_600D; bry = 1; #1;
    chk("E_err", err, 1); chk("E_ack", ack, 0);
    nx(); quiet(); #1; chk("E_idle", rrdy, 0);

    // read burst with error on beat 2, then a normal read with bl=0
    nx(); cyc = 1; stb = 1; we = 0; adr = 32'h6000_0000; bl = 4; bry = 1;
    nx(); wrdy = 1;
    nx(); wrdy = 0; rval = 1; rack = 1; rdat = 32'h1111_0000; #1;
    chk("D_ack1", ack, 1); chk("D_err1", err, 0);
    nx(); rack = 0; rerr = 1; #1;
    chk("D_err2", err, 1); chk("D_ack2", ack, 0);
    nx(); quiet(); #1; chk("D_idle_rrdy", rrdy, 0); chk("D_idle_wval", wval, 0);
    nx(); cyc = 1; stb = 1; we = 0; adr = 32'h7000_0000; bl = 0; bry = 1;
    nx(); #1; chk("D2_wval", wval, 1); chk("D2_adr", cadr, 32'h7000_0000); chk("D2_bl", cbl, 1);
    wrdy = 1;
    nx(); wrdy = 0; rval = 1; rack = 1; rdat = 32'h2222_0009; #1;
    chk("D2_ack", ack, 1); chk("D2_lack", lack, 1); chk("D2_err", err, 0); chk("D2_dat", dato, 32'h2222_0009);
    nx(); quiet();

    // master drops cyc mid write burst: padded beat, no acks
    nx(); cyc = 1; stb = 1; we = 1; adr = 32'h8000_0000; bl = 2; dat = 32'h0000_00AA; sel = 4'hF; bry = 1;
    nx(); wrdy = 1; #1; chk("G_ack1", ack, 1);
    nx(); cyc = 0; stb = 0; bry = 0; #1;
    chk("G_pad_wval", wval, 1); chk("G_pad_sel", csel, 0); chk("G_pad_ack", ack, 0);
    nx(); wrdy = 0; #1; chk("G_rrdy", rrdy, 1);
    rval = 1; rack = 1; rlack = 1; #1; chk("G_nolack", lack, 0); chk("G_noack", ack, 0);
    nx(); quiet(); #1; chk("G_idle", rrdy, 0);

    // asynchronous reset in the middle of a read
    nx(); cyc = 1; stb = 1; we = 0; adr = 32'h9000_0000; bl = 4; bry = 1;
    nx(); #1; chk("R_wval", wval, 1);
    reset = 1; #1; chk("R_rst_wval", wval, 0); chk("R_rst_adr", cadr, 0);
    nx(); reset = 0; quiet();
    nx(); #1; chk("R_after_wval", wval, 0); chk("R_after_rrdy", rrdy, 0);

`ifdef WBI_MST_TIMEOUT_EN
    // no response: err+lack 16 cycles after the command is accepted
    nx(); cyc = 1; stb = 1; we = 1; adr = 32'hA000_0000; bl = 1; dat = 32'h0000_0F0F; bry = 1;
    nx(); wrdy = 1; #1; chk("F_ack", ack, 1);
    for (int k = 1; k <= 16; k++) begin
      nx(); wrdy = 0; #1;
      if (err || lack) early++;
    end
    chk("F_early", early, 0);
    nx(); #1; chk("F_err", err, 1); chk("F_lack", lack, 1);
    nx(); cyc = 0; stb = 0; #1; chk("F_drain_rrdy", rrdy, 1);
    rval = 1; rack = 1; rlack = 1; rtid = 0; #1; chk("F_late_lack", lack, 0); chk("F_late_ack", ack, 0);
    nx(); quiet(); #1; chk("F_drained", rrdy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
